// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU reservation station.
// Tag width, opcode encodings and the per-entry record.
package alu_pkg;

    localparam int TAG_W = 4;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;

    typedef struct packed {
        logic             busy;
        logic [4:0]       op;
        logic [31:0]      vj;
        logic [TAG_W-1:0] qj;
        logic             qj_busy;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qk;
        logic             qk_busy;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder.
// Reports whether any request is set and the index of the lowest one.
module alu_rs_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU.
// Snoops both CDBs for pending operands, issues one ready op per cycle.
module alu_rs #(
    parameter int DEPTH = 8,
    parameter int TAG_W = alu_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [4:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic             disp_qj_busy,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic             disp_qk_busy,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_alu_done,
    input  logic [TAG_W-1:0] cdb_alu_tag,
    input  logic [31:0]      cdb_alu_data,
    input  logic             cdb_lsb_done,
    input  logic [TAG_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_lsb_data,
    output logic             rs_full,
    output logic             alu_ready,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [4:0]       alu_op,
    output logic [TAG_W-1:0] tag
);

    import alu_pkg::rs_entry_t;

    localparam int IW = $clog2(DEPTH);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] busy_v;
    logic [DEPTH-1:0] ready_v;
    logic             free_ok;
    logic [IW-1:0]    free_idx;
    logic             iss_ok;
    logic [IW-1:0]    iss_idx;
    logic             iss_go;
    logic [31:0]      a_d;
    logic [31:0]      b_d;
    logic [4:0]       op_d;
    logic [TAG_W-1:0] tag_d;

    // Occupancy and readiness come from the registered state only.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_v[i]  = ent_q[i].busy;
            ready_v[i] = ent_q[i].busy & ~ent_q[i].qj_busy
                       & ~ent_q[i].qk_busy;
        end
    end

    assign rs_full = &busy_v;

    alu_rs_pick #(.N(DEPTH)) u_free (
        .req   (~busy_v),
        .valid (free_ok),
        .idx   (free_idx)
    );

    alu_rs_pick #(.N(DEPTH)) u_ready (
        .req   (ready_v),
        .valid (iss_ok),
        .idx   (iss_idx)
    );

    // Next entry state: snoop, retire the issued slot, allocate, flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && ent_q[i].qj_busy) begin
                if (cdb_alu_done && cdb_alu_tag == ent_q[i].qj) begin
                    ent_d[i].vj      = cdb_alu_data;
                    ent_d[i].qj_busy = 1'b0;
                end else if (cdb_lsb_done && cdb_lsb_tag == ent_q[i].qj) begin
                    ent_d[i].vj      = cdb_lsb_data;
                    ent_d[i].qj_busy = 1'b0;
                end
            end
            if (ent_q[i].busy && ent_q[i].qk_busy) begin
                if (cdb_alu_done && cdb_alu_tag == ent_q[i].qk) begin
                    ent_d[i].vk      = cdb_alu_data;
                    ent_d[i].qk_busy = 1'b0;
                end else if (cdb_lsb_done && cdb_lsb_tag == ent_q[i].qk) begin
                    ent_d[i].vk      = cdb_lsb_data;
                    ent_d[i].qk_busy = 1'b0;
                end
            end
        end
        if (iss_ok) begin
            ent_d[iss_idx].busy = 1'b0;
        end
        // The free slot is chosen from pre-edge busy, so never the issuing one.
        if (disp_valid && free_ok) begin
            ent_d[free_idx] = '{
                busy:    1'b1,
                op:      disp_op,
                vj:      disp_vj,
                qj:      disp_qj,
                qj_busy: disp_qj_busy,
                vk:      disp_vk,
                qk:      disp_qk,
                qk_busy: disp_qk_busy,
                dest:    disp_tag
            };
            if (disp_qj_busy) begin
                if (cdb_alu_done && cdb_alu_tag == disp_qj) begin
                    ent_d[free_idx].vj      = cdb_alu_data;
                    ent_d[free_idx].qj_busy = 1'b0;
                end else if (cdb_lsb_done && cdb_lsb_tag == disp_qj) begin
                    ent_d[free_idx].vj      = cdb_lsb_data;
                    ent_d[free_idx].qj_busy = 1'b0;
                end
            end
            if (disp_qk_busy) begin
                if (cdb_alu_done && cdb_alu_tag == disp_qk) begin
                    ent_d[free_idx].vk      = cdb_alu_data;
                    ent_d[free_idx].qk_busy = 1'b0;
                end else if (cdb_lsb_done && cdb_lsb_tag == disp_qk) begin
                    ent_d[free_idx].vk      = cdb_lsb_data;
                    ent_d[free_idx].qk_busy = 1'b0;
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    // Issue payload; zeros whenever nothing goes out.
    always_comb begin
        iss_go = iss_ok & ~flush;
        a_d    = '0;
        b_d    = '0;
        op_d   = '0;
        tag_d  = '0;
        if (iss_go) begin
            a_d   = ent_q[iss_idx].vj;
            b_d   = ent_q[iss_idx].vk;
            op_d  = ent_q[iss_idx].op;
            tag_d = ent_q[iss_idx].dest;
        end
    end

    // State and issue registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alu_ready <= 1'b0;
            a         <= '0;
            b         <= '0;
            alu_op    <= '0;
            tag       <= '0;
        end else if (rdy) begin
            ent_q     <= ent_d;
            alu_ready <= iss_go;
            a         <= a_d;
            b         <= b_d;
            alu_op    <= op_d;
            tag       <= tag_d;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs.
// Table-driven streaming issue plus directed multi-cycle sequences.
module tb_alu_rs;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        disp_valid;
    logic [4:0]  disp_op;
    logic [31:0] disp_vj;
    logic [3:0]  disp_qj;
    logic        disp_qj_busy;
    logic [31:0] disp_vk;
    logic [3:0]  disp_qk;
    logic        disp_qk_busy;
    logic [3:0]  disp_tag;
    logic        cdb_alu_done;
    logic [3:0]  cdb_alu_tag;
    logic [31:0] cdb_alu_data;
    logic        cdb_lsb_done;
    logic [3:0]  cdb_lsb_tag;
    logic [31:0] cdb_lsb_data;
    logic        rs_full;
    logic        alu_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic [3:0]  tag;

    int checks = 0;
    int errors = 0;

    alu_rs #(.DEPTH(8), .TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_op      (disp_op),
        .disp_vj      (disp_vj),
        .disp_qj      (disp_qj),
        .disp_qj_busy (disp_qj_busy),
        .disp_vk      (disp_vk),
        .disp_qk      (disp_qk),
        .disp_qk_busy (disp_qk_busy),
        .disp_tag     (disp_tag),
        .cdb_alu_done (cdb_alu_done),
        .cdb_alu_tag  (cdb_alu_tag),
        .cdb_alu_data (cdb_alu_data),
        .cdb_lsb_done (cdb_lsb_done),
        .cdb_lsb_tag  (cdb_lsb_tag),
        .cdb_lsb_data (cdb_lsb_data),
        .rs_full      (rs_full),
        .alu_ready    (alu_ready),
        .a            (a),
        .b            (b),
        .alu_op       (alu_op),
        .tag          (tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  tg;
        logic        qkb;
        logic [3:0]  qk;
        logic        ad;
        logic [3:0]  at;
        logic [31:0] adata;
        logic        ld;
        logic [3:0]  lt;
        logic [31:0] ldata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_iss(input string nm, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [4:0] eop,
                           input logic [3:0] etg);
        chk({nm, ".alu_ready"}, {31'b0, alu_ready}, 32'd1);
        chk({nm, ".a"}, a, ea);
        chk({nm, ".b"}, b, eb);
        chk({nm, ".alu_op"}, {27'b0, alu_op}, {27'b0, eop});
        chk({nm, ".tag"}, {28'b0, tag}, {28'b0, etg});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".alu_ready"}, {31'b0, alu_ready}, 32'd0);
        chk({nm, ".a"}, a, 32'd0);
    endtask

    task automatic clr();
        flush        = 1'b0;
        disp_valid   = 1'b0;
        disp_op      = '0;
        disp_vj      = '0;
        disp_qj      = '0;
        disp_qj_busy = 1'b0;
        disp_vk      = '0;
        disp_qk      = '0;
        disp_qk_busy = 1'b0;
        disp_tag     = '0;
        cdb_alu_done = 1'b0;
        cdb_alu_tag  = '0;
        cdb_alu_data = '0;
        cdb_lsb_done = 1'b0;
        cdb_lsb_tag  = '0;
        cdb_lsb_data = '0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] vj,
                        input logic qjb, input logic [3:0] qj,
                        input logic [31:0] vk, input logic qkb,
                        input logic [3:0] qk, input logic [3:0] tg);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_vj      = vj;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_vk      = vk;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_tag     = tg;
    endtask

    initial begin
        vecs[0] = '{OP_ADD, 32'd5, 32'd7, 4'd3, 1'b0, 4'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'd5, 32'd7};
        vecs[1] = '{OP_SUB, 32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 4'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'hFFFF_FFFF, 32'd1};
        vecs[2] = '{OP_MUL, 32'h1234, 32'd0, 4'd6, 1'b1, 4'd4,
                    1'b1, 4'd4, 32'hAB, 1'b0, 4'd0, 32'd0,
                    32'h1234, 32'hAB};
        vecs[3] = '{OP_XOR, 32'h10, 32'd0, 4'd7, 1'b1, 4'd0,
                    1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hCAFE,
                    32'h10, 32'hCAFE};
        vecs[4] = '{OP_OR, 32'd1, 32'd0, 4'd8, 1'b1, 4'd9,
                    1'b1, 4'd9, 32'h1111, 1'b1, 4'd9, 32'h2222,
                    32'd1, 32'h1111};
        vecs[5] = '{OP_AND, 32'd2, 32'h99, 4'd15, 1'b0, 4'd3,
                    1'b1, 4'd3, 32'hDEAD, 1'b0, 4'd0, 32'd0,
                    32'd2, 32'h99};

        rst = 1'b0;
        rdy = 1'b1;
        clr();
        #12;
        chk_idle("reset");
        chk("reset.rs_full", {31'b0, rs_full}, 32'd0);
        chk("reset.tag", {28'b0, tag}, 32'd0);
        rst = 1'b1;

        disp(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        step();
        clr();
        chk_idle("t1.e0");
        step();
        chk_iss("t1.e1", 32'd5, 32'd7, OP_ADD, 4'd3);
        step();
        chk_idle("t1.e2");

        for (int i = 0; i < 6; i++) begin
            disp(vecs[i].op, vecs[i].vj, 1'b0, 4'd0, vecs[i].vk,
                 vecs[i].qkb, vecs[i].qk, vecs[i].tg);
            cdb_alu_done = vecs[i].ad;
            cdb_alu_tag  = vecs[i].at;
            cdb_alu_data = vecs[i].adata;
            cdb_lsb_done = vecs[i].ld;
            cdb_lsb_tag  = vecs[i].lt;
            cdb_lsb_data = vecs[i].ldata;
            step();
            if (i > 0) begin
                chk_iss($sformatf("vec%0d", i - 1), vecs[i-1].exp_a,
                        vecs[i-1].exp_b, vecs[i-1].op, vecs[i-1].tg);
            end
        end
        clr();
        step();
        chk_iss("vec5", vecs[5].exp_a, vecs[5].exp_b,
                vecs[5].op, vecs[5].tg);
        step();
        chk_idle("vec.drain");

        disp(OP_SUB, 32'd0, 1'b1, 4'd9, 32'd2, 1'b0, 4'd0, 4'd5);
        step();
        clr();
        step();
        chk_idle("t2.e1");
        step();
        chk_idle("t2.e2");
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd9;
        cdb_lsb_data = 32'h100;
        step();
        clr();
        chk_idle("t2.e3");
        step();
        chk_iss("t2.e4", 32'h100, 32'd2, OP_SUB, 4'd5);
        step();
        chk_idle("t2.e5");

        for (int k = 0; k < 8; k++) begin
            disp(OP_ADD, 32'd0, 1'b1, 4'(8 + k), 32'(k), 1'b0, 4'd0,
                 4'(k));
            step();
            chk($sformatf("t4.full%0d", k), {31'b0, rs_full},
                (k == 7) ? 32'd1 : 32'd0);
        end
        disp(OP_ADD, 32'hEE, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd15);
        step();
        clr();
        chk("t4.still_full", {31'b0, rs_full}, 32'd1);
        step();
        chk_idle("t4.no_extra");
        cdb_alu_done = 1'b1;
        cdb_alu_tag  = 4'd10;
        cdb_alu_data = 32'h22;
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd13;
        cdb_lsb_data = 32'h55;
        step();
        clr();
        chk_idle("t4.capture");
        step();
        chk_iss("t4.e2", 32'h22, 32'd2, OP_ADD, 4'd2);
        chk("t4.freed", {31'b0, rs_full}, 32'd0);
        step();
        chk_iss("t4.e5", 32'h55, 32'd5, OP_ADD, 4'd5);
        step();
        chk_idle("t4.rest");
        flush = 1'b1;
        step();
        clr();
        chk("t4.flushed", {31'b0, rs_full}, 32'd0);

        disp(OP_ADD, 32'hA1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd1);
        step();
        disp(OP_ADD, 32'hA2, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd2);
        step();
        disp(OP_ADD, 32'hA3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd3);
        step();
        chk_iss("t5.pre", 32'hA2, 32'd2, OP_ADD, 4'd2);
        disp(OP_ADD, 32'hA4, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd4);
        flush = 1'b1;
        step();
        clr();
        chk_idle("t5.flush");
        chk("t5.rs_full", {31'b0, rs_full}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("t5.after%0d", i));
        end

        disp(OP_ADD, 32'd0, 1'b1, 4'd7, 32'd2, 1'b0, 4'd0, 4'd2);
        step();
        disp(OP_XOR, 32'h11, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd1);
        step();
        disp(OP_OR, 32'h33, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd3);
        step();
        clr();
        chk_iss("t6.pre", 32'h11, 32'd1, OP_XOR, 4'd1);
        rdy          = 1'b0;
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd7;
        cdb_lsb_data = 32'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_iss($sformatf("t6.hold%0d", i), 32'h11, 32'd1,
                    OP_XOR, 4'd1);
        end
        rdy = 1'b1;
        clr();
        step();
        chk_iss("t6.resume", 32'h33, 32'd3, OP_OR, 4'd3);
        step();
        chk_idle("t6.nocap");
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd7;
        cdb_lsb_data = 32'h77;
        step();
        clr();
        chk_idle("t6.capture");
        step();
        chk_iss("t6.late", 32'h77, 32'd2, OP_ADD, 4'd2);

        disp(OP_ADD, 32'h5A, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd9);
        step();
        disp(OP_ADD, 32'h5B, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd10);
        step();
        clr();
        chk_iss("t7.pre", 32'h5A, 32'd1, OP_ADD, 4'd9);
        #2 rst = 1'b0;
        #1;
        chk_idle("t7.async");
        chk("t7.tag", {28'b0, tag}, 32'd0);
        #2 rst = 1'b1;
        step();
        chk_idle("t7.after");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
